countdown_sequencer: RTL and testbench
======================================

COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

Interface
REQ-001 The block SHALL declare parameter TIMEOUT, default 15, the maximum number of cycles cnt_q may hold one value while RUN before a timeout is declared.
REQ-002 The block SHALL declare the following ports:
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- cmd_valid  in  1  run-request valid
- cmd_ready  out  1  high when a request can be accepted
- cmd_runs  in  4  number of countdowns requested; 0 means 16
- abort  in  1  cancel current request
- cnt_start  out  1  start/enable request to the countdown counter
- cnt_ready  in  1  counter reload indication
- cnt_q  in  5  counter value; legal sequence 8,7,...,1,0, then 8
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a request completes normally
- runs_done  out  5  countdowns completed in current/last request
- seq_err  out  1  sticky illegal-transition flag
- timeout  out  1  sticky stall flag
- err_count  out  8  saturating count of illegal transitions

Function
REQ-003 The block SHALL implement states IDLE, RUN and DONE.
REQ-004 In IDLE, cmd_ready SHALL be 1; a handshake SHALL occur when cmd_valid and cmd_ready are both 1 on a clock edge.
REQ-005 On handshake the block SHALL latch remaining = cmd_runs, or 16 when cmd_runs is 0, clear runs_done, and enter RUN next cycle.
REQ-006 cmd_ready SHALL be 0 in RUN and DONE; cmd_valid SHALL be ignored there.
REQ-007 cnt_start SHALL be combinational: 1 in RUN when remaining > 1, or when cnt_q != 0; otherwise 0.
- Consequence: cnt_start is low exactly in the final q==0 cycle, and in IDLE and DONE.
REQ-008 A countdown SHALL be counted complete on each RUN cycle with cnt_q == 0.
- That cycle: runs_done increments by 1 and remaining decrements by 1.
REQ-009 When remaining is decremented from 1 to 0, the block SHALL enter DONE next cycle.
- DONE: done = 1 for exactly one cycle, then IDLE.
- runs_done SHALL hold its value until the next handshake.
REQ-010 The monitor SHALL register the previous cnt_q each cycle while RUN.
- On the first RUN cycle no check SHALL be made.
- Afterwards a transition is legal iff cnt_q == prev-1, or (prev == 0 and cnt_q == 8), or (prev == 8 and cnt_q == 8 and cnt_ready == 1).
- Any other transition SHALL set seq_err and increment err_count, saturating at 255.
- cnt_q > 8 SHALL always be illegal.
REQ-011 A stall counter SHALL count consecutive RUN cycles with cnt_q unchanged and reset on any change.
- When it exceeds TIMEOUT: set timeout, enter IDLE next cycle, no done pulse.
REQ-012 abort = 1 in RUN or DONE SHALL return the block to IDLE next cycle with no done pulse.
- runs_done SHALL retain the completed count.
- abort SHALL take priority over completion, timeout and the DONE pulse in the same cycle.
REQ-013 seq_err, timeout and err_count SHALL be cleared only by reset or by a new handshake.
REQ-014 A sequence error SHALL NOT stop the run; counting per REQ-008 SHALL continue.
REQ-015 busy SHALL equal (state == RUN).

Reset
REQ-016 While rst_n is 0 at a clock edge, the block SHALL enter IDLE with the following values:
- remaining = 0, runs_done = 0, err_count = 0
- seq_err = 0, timeout = 0, done = 0
- stall counter and prev cleared
- Next cycle: cnt_start = 0, busy = 0, cmd_ready = 1.
REQ-017 Reset asserted mid-RUN SHALL abandon the request without a done pulse.
REQ-018 Reset SHALL take priority over abort and handshake.

Verification
REQ-019 Handshake cmd_runs=2 with a golden counter model (reload 8, countdown to 0):
- cnt_start held 1 through the first q==0 and low on the second.
- runs_done = 2, one done pulse, return to IDLE.
- seq_err = 0.
REQ-020 cmd_runs=0 -> 16 countdowns completed, runs_done = 16, single done pulse.
REQ-021 Inject cnt_q 5 -> 3 mid-run:
- seq_err = 1, err_count = 1, run still completes with done.
- Repeat 300 injections -> err_count = 255.
REQ-022 Freeze cnt_q at 4 for 16 cycles -> timeout = 1, IDLE, no done, runs_done unchanged.
REQ-023 Assert abort on the q==0 cycle of the final countdown -> no done pulse, IDLE next cycle.
REQ-024 Deassert rst_n mid-RUN -> all outputs at reset values next cycle; cmd_valid held high during reset is not accepted.

Source files
------------

// File: rtl/countdown_sequencer_if.sv
// countdown_sequencer_if: request handshake, counter link and status bundle for the countdown sequencer.
interface countdown_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_runs;
    logic       abort;
    logic       cnt_start;
    logic       cnt_ready;
    logic [4:0] cnt_q;
    logic       busy;
    logic       done;
    logic [4:0] runs_done;
    logic       seq_err;
    logic       timeout;
    logic [7:0] err_count;
    modport master (
        output cmd_valid, cmd_runs, abort, cnt_ready, cnt_q,
        input  cmd_ready, cnt_start, busy, done, runs_done, seq_err, timeout, err_count
    );
    modport slave (
        input  cmd_valid, cmd_runs, abort, cnt_ready, cnt_q,
        output cmd_ready, cnt_start, busy, done, runs_done, seq_err, timeout, err_count
    );
endinterface

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: runs N countdowns of an external 8..0 counter, checking its sequence and watching for stalls.
module countdown_sequencer #(
    parameter int TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    countdown_sequencer_if.slave bus
);
    localparam int SW = $clog2(TIMEOUT + 2);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state;
    logic [4:0]    remaining, runs_done, prev;
    logic [7:0]    err_count;
    logic [SW-1:0] stall, hold;
    logic          first, seq_err, timeout, step_ok, bad;
    // hold is the number of cycles the current cnt_q value has been seen, including this one
    always_comb begin
        hold    = (!first && bus.cnt_q == prev) ? stall + SW'(1) : SW'(1);
        step_ok = ({1'b0, bus.cnt_q} + 6'd1 == {1'b0, prev}) ||
                  (prev == 5'd0 && bus.cnt_q == 5'd8) ||
                  (prev == 5'd8 && bus.cnt_q == 5'd8 && bus.cnt_ready);
        bad     = bus.cnt_q > 5'd8 || (!first && !step_ok);
    end
    assign bus.cmd_ready = state == IDLE;
    assign bus.busy      = state == RUN;
    assign bus.done      = state == DONE && !bus.abort;
    assign bus.cnt_start = state == RUN && (remaining > 5'd1 || bus.cnt_q != 5'd0);
    assign bus.runs_done = runs_done;
    assign bus.seq_err   = seq_err;
    assign bus.timeout   = timeout;
    assign bus.err_count = err_count;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= 5'd0;
            runs_done <= 5'd0;
            prev      <= 5'd0;
            err_count <= 8'd0;
            stall     <= '0;
            first     <= 1'b0;
            seq_err   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    state     <= RUN;
                    remaining <= bus.cmd_runs == 4'd0 ? 5'd16 : {1'b0, bus.cmd_runs};
                    runs_done <= 5'd0;
                    err_count <= 8'd0;
                    seq_err   <= 1'b0;
                    timeout   <= 1'b0;
                    stall     <= '0;
                    first     <= 1'b1;
                end
                RUN: begin
                    prev  <= bus.cnt_q;
                    first <= 1'b0;
                    stall <= hold;
                    if (bad) begin
                        seq_err   <= 1'b1;
                        err_count <= err_count + {7'd0, err_count != 8'hff};
                    end
                    if (bus.abort) state <= IDLE;
                    else if (hold > SW'(TIMEOUT)) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else if (bus.cnt_q == 5'd0) begin
                        runs_done <= runs_done + 5'd1;
                        remaining <= remaining - 5'd1;
                        if (remaining == 5'd1) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: directed bench with a golden 8..0 counter model and a done/runs_done scoreboard.
module tb_countdown_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    countdown_sequencer_if bus ();
    countdown_sequencer #(.TIMEOUT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_cmp = 0;
    int n_err = 0;
    int dones;
    int n;
    logic [4:0] sb[$];
    logic zs[$];
    logic [4:0] mq = 5'd8;
    logic skip = 1'b0, hold = 1'b0, ovr = 1'b0;
    logic [4:0] ovr_val = 5'd0;
    // golden counter: parked at 8 while not busy, optional skip/freeze/override fault injection
    always @(posedge clk) begin
        if (!bus.busy) mq <= 5'd8;
        else if (hold) mq <= mq;
        else if (skip && mq == 5'd5) mq <= 5'd3;
        else if (bus.cnt_start) mq <= mq == 5'd0 ? 5'd8 : mq - 5'd1;
    end
    assign bus.cnt_ready = mq == 5'd8;
    assign bus.cnt_q = ovr ? ovr_val : mq;
    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic go(input logic [3:0] runs);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_runs = runs;
        sb.push_back(runs == 4'd0 ? 5'd16 : {1'b0, runs});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask
    task automatic wait_idle(input int budget);
        dones = 0;
        zs.delete();
        for (int i = 0; i < budget; i++) begin
            if (bus.done) begin
                dones++;
                if (sb.size() != 0) chk("sb_runs_done", bus.runs_done, sb.pop_front());
                else chk("sb_empty", sb.size(), 1);
            end
            if (bus.busy && bus.cnt_q == 5'd0) zs.push_back(bus.cnt_start);
            if (bus.cmd_ready) return;
            @(negedge clk);
        end
        chk("idle_budget", bus.cmd_ready, 1);
    endtask
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_runs = 4'd0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cnt_start", bus.cnt_start, 0);
        chk("rst_runs_done", bus.runs_done, 0);
        chk("rst_err_count", bus.err_count, 0);
        chk("rst_seq_err", bus.seq_err, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        go(4'd2);
        wait_idle(100);
        chk("r2_dones", dones, 1);
        chk("r2_runs_done", bus.runs_done, 2);
        chk("r2_seq_err", bus.seq_err, 0);
        chk("r2_zero_cycles", zs.size(), 2);
        if (zs.size() == 2) begin
            chk("r2_start_first_zero", zs[0], 1);
            chk("r2_start_last_zero", zs[1], 0);
        end
        go(4'd0);
        wait_idle(300);
        chk("r16_dones", dones, 1);
        chk("r16_runs_done", bus.runs_done, 16);
        chk("r16_seq_err", bus.seq_err, 0);
        skip = 1'b1;
        go(4'd1);
        wait_idle(100);
        skip = 1'b0;
        chk("inj_dones", dones, 1);
        chk("inj_seq_err", bus.seq_err, 1);
        chk("inj_err_count", bus.err_count, 1);
        chk("inj_runs_done", bus.runs_done, 1);
        go(4'd3);
        ovr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ovr_val = i[0] ? 5'd5 : 5'd3;
            @(negedge clk);
        end
        chk("sat_err_count", bus.err_count, 255);
        chk("sat_still_busy", bus.busy, 1);
        ovr = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("sat_abort_idle", bus.cmd_ready, 1);
        chk("sat_sticky", bus.err_count, 255);
        sb.delete();
        go(4'd2);
        n = 0;
        while (mq != 5'd4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("frz_reach4", mq, 4);
        hold = 1'b1;
        n = 0;
        dones = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done) dones++;
        end
        hold = 1'b0;
        chk("frz_cycles", n, 16);
        chk("frz_timeout", bus.timeout, 1);
        chk("frz_idle", bus.cmd_ready, 1);
        chk("frz_no_done", dones, 0);
        chk("frz_runs_done", bus.runs_done, 0);
        sb.delete();
        go(4'd2);
        chk("new_hs_clears_timeout", bus.timeout, 0);
        n = 0;
        while (!(bus.busy && bus.cnt_q == 5'd0 && !bus.cnt_start) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ab_final_zero", bus.cnt_start, 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("ab_no_done", bus.done, 0);
        chk("ab_idle", bus.cmd_ready, 1);
        chk("ab_busy", bus.busy, 0);
        @(negedge clk);
        chk("ab_no_late_done", bus.done, 0);
        sb.delete();
        go(4'd3);
        repeat (15) @(negedge clk);
        chk("mid_runs_done", bus.runs_done, 1);
        bus.cmd_valid = 1'b1;
        bus.abort = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_cmd_ready", bus.cmd_ready, 1);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_cnt_start", bus.cnt_start, 0);
        chk("mrst_runs_done", bus.runs_done, 0);
        chk("mrst_done", bus.done, 0);
        @(negedge clk);
        chk("mrst_not_accepted", bus.busy, 0);
        rst_n = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("mrst_after_release", bus.busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
